seg7_scan_decoder: RTL and testbench

- Receive side of the 7-segment display interface.
- Samples a multiplexed segment bus (a..g plus per-digit selects), waits for each scan slot to be stable, and converts the segment pattern back to the 4-bit display code.
- Holds one code and one valid flag per digit.
- Used as an on-board and bench monitor that checks the FSM display path end to end.

---
 rtl/seg7_pkg.sv | 34 +++
 rtl/seg7_scan_decoder_if.sv | 32 +++
 rtl/seg7_pattern_to_code.sv | 29 ++
 rtl/seg7_scan_decoder.sv | 174 +++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seg7_pkg : segment patterns, display codes and decoder FSM states
// Rev 1.0
// ---------------------------------------------------------------------------
package seg7_pkg;

  // Active-high patterns, bit 6 = segment a ... bit 0 = segment g
  localparam logic [6:0] SEG_OFF = 7'b0000000;
  localparam logic [6:0] SEG_Y   = 7'b0110011;
  localparam logic [6:0] SEG_S   = 7'b1011011;
  localparam logic [6:0] SEG_G   = 7'b1011111;
  localparam logic [6:0] SEG_A   = 7'b1110111;
  localparam logic [6:0] SEG_E   = 7'b1001111;
  localparam logic [6:0] SEG_F   = 7'b1000111;
  localparam logic [6:0] SEG_P   = 7'b1100111;

  localparam logic [3:0] CODE_OFF = 4'd0;
  localparam logic [3:0] CODE_Y   = 4'd4;
  localparam logic [3:0] CODE_S   = 4'd5;
  localparam logic [3:0] CODE_G   = 4'd6;
  localparam logic [3:0] CODE_A   = 4'd10;
  localparam logic [3:0] CODE_E   = 4'd14;
  localparam logic [3:0] CODE_F   = 4'd15;
  localparam logic [3:0] CODE_P   = 4'd1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HELD   = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/seg7_scan_decoder_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seg7_scan_decoder_if : multiplexed segment bus plus decoded results
// Rev 1.0
// ---------------------------------------------------------------------------
interface seg7_scan_decoder_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic                    i_a, i_b, i_c, i_d, i_e, i_f, i_g;
  logic [NUM_DIGITS-1:0]   i_dig;
  logic                    i_clr_err;
  logic [4*NUM_DIGITS-1:0] o_code;
  logic [NUM_DIGITS-1:0]   o_valid;
  logic                    o_update;
  logic [IDX_W-1:0]        o_upd_idx;
  logic                    o_err_pattern;
  logic                    o_err_multi;

  modport master (
    output i_a, i_b, i_c, i_d, i_e, i_f, i_g, i_dig, i_clr_err,
    input  o_code, o_valid, o_update, o_upd_idx, o_err_pattern, o_err_multi
  );

  modport slave (
    input  i_a, i_b, i_c, i_d, i_e, i_f, i_g, i_dig, i_clr_err,
    output o_code, o_valid, o_update, o_upd_idx, o_err_pattern, o_err_multi
  );

endinterface
`default_nettype wire

// File: rtl/seg7_pattern_to_code.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seg7_pattern_to_code : active-high segment pattern -> {recognised, code}
// Rev 1.0
// ---------------------------------------------------------------------------
module seg7_pattern_to_code
  import seg7_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [4:0] match_o
);

  always_comb begin
    match_o = 5'b0_0000;
    case (seg_i)
      SEG_OFF: match_o = {1'b1, CODE_OFF};
      SEG_Y:   match_o = {1'b1, CODE_Y};
      SEG_S:   match_o = {1'b1, CODE_S};
      SEG_G:   match_o = {1'b1, CODE_G};
      SEG_A:   match_o = {1'b1, CODE_A};
      SEG_E:   match_o = {1'b1, CODE_E};
      SEG_F:   match_o = {1'b1, CODE_F};
      SEG_P:   match_o = {1'b1, CODE_P};
      default: match_o = 5'b0_0000;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_decoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seg7_scan_decoder : samples a scanned 7-segment bus and recovers per-digit codes
// Rev 1.0
// ---------------------------------------------------------------------------
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS           = 4,
  parameter int COMMON_ANODE_CATHODE = 0,
  parameter int DIG_ACTIVE_LOW       = 1,
  parameter int STABLE_CYCLES        = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  seg7_scan_decoder_if.slave bus
);

  localparam int         IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int         W          = 7 + NUM_DIGITS;
  localparam logic       SEG_IDLE   = (COMMON_ANODE_CATHODE != 0) ? 1'b0 : 1'b1;
  localparam logic       DIG_IDLE   = (DIG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [W-1:0] RAW_IDLE = {{7{SEG_IDLE}}, {NUM_DIGITS{DIG_IDLE}}};
  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

  logic [W-1:0]            raw;
  logic [W-1:0]            sync1_q, sync2_q;
  logic [6:0]              seg_n;
  logic [NUM_DIGITS-1:0]   sel_n;
  logic [W-1:0]            sample, prev_q;
  logic                    changed;
  logic [7:0]              cnt_q, cnt_d;
  state_t                  state_q, state_d;
  int                      n_sel;
  logic [IDX_W-1:0]        sel_idx;
  logic                    one_hot, multi;
  logic                    commit, multi_evt;
  logic [4:0]              match;
  logic [4*NUM_DIGITS-1:0] code_q;
  logic [NUM_DIGITS-1:0]   valid_q;
  logic                    update_q;
  logic [IDX_W-1:0]        upd_idx_q;
  logic                    err_pattern_q, err_multi_q;

  assign raw = {bus.i_a, bus.i_b, bus.i_c, bus.i_d, bus.i_e, bus.i_f, bus.i_g, bus.i_dig};

  // Synchronisers idle at the inactive bus level so reset release looks like "nothing shown"
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync1_q <= RAW_IDLE;
      sync2_q <= RAW_IDLE;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  assign seg_n   = (COMMON_ANODE_CATHODE != 0) ? sync2_q[W-1 -: 7] : ~sync2_q[W-1 -: 7];
  assign sel_n   = (DIG_ACTIVE_LOW != 0) ? ~sync2_q[NUM_DIGITS-1:0] : sync2_q[NUM_DIGITS-1:0];
  assign sample  = {seg_n, sel_n};
  assign changed = (sample != prev_q);

  always_comb begin
    cnt_d = cnt_q;
    if (changed)
      cnt_d = 8'd1;
    else if (cnt_q >= STABLE_MAX)
      cnt_d = STABLE_MAX;
    else
      cnt_d = cnt_q + 8'd1;
  end

  always_comb begin
    n_sel   = 0;
    sel_idx = '0;
    for (int n = 0; n < NUM_DIGITS; n++) begin
      if (sel_n[n]) begin
        n_sel   = n_sel + 1;
        sel_idx = IDX_W'(n);
      end
    end
  end

  assign one_hot = (n_sel == 1);
  assign multi   = (n_sel > 1);

  seg7_pattern_to_code u_lookup (
    .seg_i   (seg_n),
    .match_o (match)
  );

  // Decisions use the next count so a commit lands on the edge the count saturates
  always_comb begin
    state_d   = state_q;
    commit    = 1'b0;
    multi_evt = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (n_sel != 0)
          state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_d == STABLE_MAX) begin
          if (one_hot) begin
            commit  = 1'b1;
            state_d = ST_HELD;
          end else if (multi) begin
            multi_evt = 1'b1;
            state_d   = ST_HELD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_HELD: begin
        if (changed)
          state_d = one_hot ? ST_SETTLE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= sample;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      code_q        <= '0;
      valid_q       <= '0;
      update_q      <= 1'b0;
      upd_idx_q     <= '0;
      err_pattern_q <= 1'b0;
      err_multi_q   <= 1'b0;
    end else begin
      update_q <= commit;
      if (commit)
        upd_idx_q <= sel_idx;
      for (int n = 0; n < NUM_DIGITS; n++) begin
        if (commit && sel_n[n]) begin
          if (match[4])
            code_q[4*n +: 4] <= match[3:0];
          valid_q[n] <= match[4];
        end
      end
      // A new error event takes priority over a coincident clear
      if (commit && !match[4])
        err_pattern_q <= 1'b1;
      else if (bus.i_clr_err)
        err_pattern_q <= 1'b0;
      if (multi_evt)
        err_multi_q <= 1'b1;
      else if (bus.i_clr_err)
        err_multi_q <= 1'b0;
    end
  end

  assign bus.o_code        = code_q;
  assign bus.o_valid       = valid_q;
  assign bus.o_update      = update_q;
  assign bus.o_upd_idx     = upd_idx_q;
  assign bus.o_err_pattern = err_pattern_q;
  assign bus.o_err_multi   = err_multi_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_decoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_seg7_scan_decoder : directed stimulus with a commit scoreboard
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_seg7_scan_decoder;
  import seg7_pkg::*;

  typedef struct {
    int         idx;
    logic [3:0] code;
    logic       valid;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   upd_count = 0;
  int   last_upd_cyc = -1;
  exp_t exp_q[$];

  seg7_scan_decoder_if #(.NUM_DIGITS(4)) bus ();

  seg7_scan_decoder #(
    .NUM_DIGITS(4), .COMMON_ANODE_CATHODE(0), .DIG_ACTIVE_LOW(1), .STABLE_CYCLES(4)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Segment and digit inputs are active-low for the default build
  task automatic drive(input logic [6:0] seg, input logic [3:0] sel);
    {bus.i_a, bus.i_b, bus.i_c, bus.i_d, bus.i_e, bus.i_f, bus.i_g} = ~seg;
    bus.i_dig = ~sel;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int idx, input logic [3:0] code, input logic valid);
    exp_t e;
    e.idx = idx; e.code = code; e.valid = valid;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.o_update) begin
      exp_t e;
      upd_count    = upd_count + 1;
      last_upd_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_commit: idx %0d code 0x%0h", bus.o_upd_idx, bus.o_code);
      end else begin
        e = exp_q.pop_front();
        check("upd_idx", 32'(bus.o_upd_idx), 32'(e.idx));
        check("commit_code", 32'(bus.o_code[4*e.idx +: 4]), 32'(e.code));
        check("commit_valid", 32'(bus.o_valid[e.idx]), 32'(e.valid));
      end
    end
  end

  logic [6:0] pats [4];
  logic [3:0] codes[4];
  int         k;
  int         base;

  initial begin
    pats  = '{SEG_S, SEG_G, SEG_A, SEG_F};
    codes = '{4'd5, 4'd6, 4'd10, 4'd15};
    bus.i_clr_err = 1'b0;
    drive(SEG_OFF, 4'b0000);
    step(3);

    check("rst_code", 32'(bus.o_code), 32'h0);
    check("rst_valid", 32'(bus.o_valid), 32'h0);
    check("rst_update", 32'(bus.o_update), 32'h0);
    check("rst_upd_idx", 32'(bus.o_upd_idx), 32'h0);
    check("rst_errs", 32'({bus.o_err_pattern, bus.o_err_multi}), 32'h0);

    // Reset lands while digit 1 is still settling
    rst = 1'b0;
    step(1);
    drive(SEG_Y, 4'b0010);
    step(3);
    #2 rst = 1'b1;
    drive(SEG_OFF, 4'b0000);
    step(3);
    rst = 1'b0;
    step(12);
    check("midreset_no_update", 32'(upd_count), 32'd0);
    check("midreset_code", 32'(bus.o_code), 32'h0);
    check("midreset_valid", 32'(bus.o_valid), 32'h0);

    // Single slot: Y on digit 2, expect the pulse on edge 6
    base = upd_count;
    push(2, CODE_Y, 1'b1);
    k = cyc;
    drive(SEG_Y, 4'b0100);
    step(10);
    check("y_pulses", 32'(upd_count - base), 32'd1);
    check("y_latency", 32'(last_upd_cyc), 32'(k + 6));
    check("y_code", 32'(bus.o_code[11:8]), 32'd4);
    check("y_valid", 32'(bus.o_valid), 32'b0100);
    drive(SEG_OFF, 4'b0000);
    step(6);

    // Four-digit scan, 8 cycles per slot
    base = upd_count;
    for (int d = 0; d < 4; d++) begin
      push(d, codes[d], 1'b1);
      drive(pats[d], 4'(1 << d));
      step(8);
    end
    drive(SEG_OFF, 4'b0000);
    step(6);
    check("scan_pulses", 32'(upd_count - base), 32'd4);
    check("scan_code", 32'(bus.o_code), 32'hFA65);
    check("scan_valid", 32'(bus.o_valid), 32'hF);

    // Short glitch value must never be committed
    base = upd_count;
    push(0, CODE_E, 1'b1);
    drive(SEG_G, 4'b0001);
    step(2);
    drive(SEG_E, 4'b0001);
    step(10);
    check("glitch_pulses", 32'(upd_count - base), 32'd1);
    check("glitch_code", 32'(bus.o_code), 32'hFA6E);
    drive(SEG_OFF, 4'b0000);
    step(6);

    // Unrecognised "8" on digit 0 keeps the stored code
    base = upd_count;
    push(0, CODE_E, 1'b0);
    drive(7'b1111111, 4'b0001);
    step(10);
    check("bad_pulses", 32'(upd_count - base), 32'd1);
    check("bad_err_pattern", 32'(bus.o_err_pattern), 32'd1);
    check("bad_valid", 32'(bus.o_valid), 32'hE);
    check("bad_code_kept", 32'(bus.o_code), 32'hFA6E);
    drive(SEG_OFF, 4'b0000);
    step(4);
    bus.i_clr_err = 1'b1;
    step(1);
    bus.i_clr_err = 1'b0;
    check("clr_err_pattern", 32'(bus.o_err_pattern), 32'd0);
    check("no_err_multi_yet", 32'(bus.o_err_multi), 32'd0);

    // No digit selected, then two digits selected together
    base = upd_count;
    drive(SEG_OFF, 4'b0000);
    step(10);
    check("nosel_err_multi", 32'(bus.o_err_multi), 32'd0);
    drive(SEG_S, 4'b0101);
    step(10);
    check("multi_flag", 32'(bus.o_err_multi), 32'd1);
    bus.i_clr_err = 1'b1;
    step(1);
    bus.i_clr_err = 1'b0;
    step(10);
    check("multi_once", 32'(bus.o_err_multi), 32'd0);
    check("multi_no_commit", 32'(upd_count - base), 32'd0);
    check("multi_err_pattern", 32'(bus.o_err_pattern), 32'd0);
    drive(SEG_OFF, 4'b0000);
    step(6);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
